// File: rtl/sram_port_ctrl_if.sv
// Request/response bundle for sram_port_ctrl: valid/ready request channel plus buffered read returns.
// Latency: none, wires only.
// Backpressure: req_ready is a credit from the slave and rsp_ready stalls the response head.
interface sram_port_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16384
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BYTE_W = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [BYTE_W-1:0] req_web;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_web, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_web, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/sram_port_ctrl.sv
// Single-port SRAM with byte-lane writes, address range check and a credit-guarded read-response FIFO.
// Latency: read response 1 cycle after accept (2 with macro SRAM_RDATA_REG_EN); writes commit at accept.
// Backpressure: req_ready drops once buffered plus in-flight reads reach BUF_DEPTH; rsp_ready pops the head.

// Small synchronous FIFO; the caller guarantees no push when full and no pop when empty.
module sync_fifo #(
    parameter int   W     = 8,
    parameter int   DEPTH = 2,
    localparam int  CW    = $clog2(DEPTH + 1),
    localparam int  PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          CK,
    input  logic          RSTn,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count
);
    logic [W-1:0]  store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head_dat = store[rd_ptr];

    // Storage, pointers and occupancy; reset flushes everything at once.
    always_ff @(posedge CK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < DEPTH; i++) store[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                store[wr_ptr] <= push_dat;
                wr_ptr        <= nxt(wr_ptr);
            end
            if (pop) rd_ptr <= nxt(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module sram_port_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16384
) (
    input  logic           CK,
    input  logic           RSTn,
    sram_port_ctrl_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int BYTE_W = DATA_W / 8;
`ifdef SRAM_RDATA_REG_EN
    localparam int BUF_DEPTH = 3;
`else
    localparam int BUF_DEPTH = 2;
`endif
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              accept;
    logic              rd_acc;
    logic              in_range;
    logic [DATA_W-1:0] rd_word;
    logic              pipe_valid;
    logic              push;
    logic [DATA_W:0]   push_dat;
    logic              pop;
    logic [DATA_W:0]   head_dat;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       credit_used;

    // Credits come only from registered state, so req_ready never depends on req_valid or rsp_ready.
    assign credit_used   = {1'b0, fifo_count} + {{CW{1'b0}}, pipe_valid};
    assign bus.req_ready = credit_used < (CW + 1)'(BUF_DEPTH);

    assign accept   = bus.req_valid && bus.req_ready;
    assign rd_acc   = accept && !bus.req_we;
    assign in_range = {1'b0, bus.req_addr} < DEPTH_L;
    // Out-of-range reads never touch the array and return zero.
    assign rd_word  = in_range ? mem[bus.req_addr] : '0;

    // Byte-lane writes with active-low enables; out-of-range writes are dropped. Contents survive reset.
    always_ff @(posedge CK) begin
        if (accept && bus.req_we && in_range) begin
            for (int i = 0; i < BYTE_W; i++) begin
                if (!bus.req_web[i]) mem[bus.req_addr][8*i +: 8] <= bus.req_wdata[8*i +: 8];
            end
        end
    end

`ifdef SRAM_RDATA_REG_EN
    logic [DATA_W:0] pipe_dat;

    // Output register between array and FIFO; it holds one credit while occupied.
    always_ff @(posedge CK or negedge RSTn) begin
        if (!RSTn) begin
            pipe_valid <= 1'b0;
            pipe_dat   <= '0;
        end else begin
            pipe_valid <= rd_acc;
            if (rd_acc) pipe_dat <= {!in_range, rd_word};
        end
    end

    assign push     = pipe_valid;
    assign push_dat = pipe_dat;
`else
    assign pipe_valid = 1'b0;
    assign push       = rd_acc;
    assign push_dat   = {!in_range, rd_word};
`endif

    assign pop = bus.rsp_valid && bus.rsp_ready;

    sync_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (BUF_DEPTH)
    ) u_rsp_fifo (
        .CK       (CK),
        .RSTn     (RSTn),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (fifo_count)
    );

    // Response outputs read as zero whenever the buffer is empty.
    assign bus.rsp_valid = (fifo_count != '0);
    assign bus.rsp_rdata = bus.rsp_valid ? head_dat[DATA_W-1:0] : '0;
    assign bus.rsp_err   = bus.rsp_valid ? head_dat[DATA_W] : 1'b0;
endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl with DEPTH = 1000 and 32-bit words.
// Latency: expected read latency and buffer depth follow SRAM_RDATA_REG_EN.
// Backpressure: exercises full-buffer stalls, in-order drain and streaming at one request per cycle.
module tb_sram_port_ctrl;
    localparam int DEPTH = 1000;
`ifdef SRAM_RDATA_REG_EN
    localparam int LAT = 2;
    localparam int BUF = 3;
`else
    localparam int LAT = 1;
    localparam int BUF = 2;
`endif

    logic CK   = 1'b0;
    logic RSTn = 1'b0;
    int   nchk  = 0;
    int   npass = 0;
    int   nfail = 0;

    always #5 CK = ~CK;

    sram_port_ctrl_if #(.DATA_W(32), .DEPTH(DEPTH)) bus ();

    sram_port_ctrl #(.DATA_W(32), .DEPTH(DEPTH)) dut (
        .CK   (CK),
        .RSTn (RSTn),
        .bus  (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic wr(input logic [9:0] addr, input logic [3:0] web, input logic [31:0] data);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = addr;
        bus.req_web   = web;
        bus.req_wdata = data;
        tick();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [9:0] addr, input logic [31:0] exp, input logic experr);
        int n;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = addr;
        tick();
        bus.req_valid = 1'b0;
        n = 1;
        while (!bus.rsp_valid && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(LAT));
        chk({tag, "_data"}, bus.rsp_rdata, exp);
        chk({tag, "_err"}, 32'(bus.rsp_err), 32'(experr));
        tick();
    endtask

    initial begin
        int          acc;
        int          got;
        int          drops;
        int          extra;
        logic        r;
        logic        v;
        logic        was_vld;
        logic [31:0] d;
        logic [31:0] last_w;
        logic [31:0] e;
        logic [31:0] expq[$];

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_web   = '1;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        RSTn = 1'b1;
        tick();

        // Full write then read back, latency measured from accept
        wr(10'd5, 4'b0000, 32'hDEADBEEF);
        rd_chk("full_wr", 10'd5, 32'hDEADBEEF, 1'b0);
        chk("idle_after_pop", 32'(bus.rsp_valid), 32'd0);

        // Partial write: lanes 0 and 2 updated
        wr(10'd5, 4'b1010, 32'h11223344);
        rd_chk("part_wr", 10'd5, 32'hDE22BE44, 1'b0);

        // All-ones byte enable is a no-op
        wr(10'd5, 4'b1111, 32'h00000000);
        rd_chk("noop_wr", 10'd5, 32'hDE22BE44, 1'b0);

        // Back-pressure: only BUF reads accepted while rsp_ready is low
        for (int i = 0; i < 4; i++) wr(10'(i), 4'b0000, 32'hC0DE0000 + 32'(i));
        bus.rsp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            if (acc < 4) begin
                bus.req_valid = 1'b1;
                bus.req_we    = 1'b0;
                bus.req_addr  = 10'(acc);
            end else begin
                bus.req_valid = 1'b0;
            end
            r       = bus.req_ready;
            was_vld = bus.req_valid;
            tick();
            if (r && was_vld) acc++;
        end
        chk("bp_accepted", 32'(acc), 32'(BUF));
        chk("bp_ready_low", 32'(bus.req_ready), 32'd0);
        chk("bp_head_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp_head_data", bus.rsp_rdata, 32'hC0DE0000);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        got = 1;
        chk("bp_ready_after_pop", 32'(bus.req_ready), 32'd1);
        for (int c = 0; c < 40 && got < 4; c++) begin
            if (acc < 4) begin
                bus.req_valid = 1'b1;
                bus.req_we    = 1'b0;
                bus.req_addr  = 10'(acc);
            end else begin
                bus.req_valid = 1'b0;
            end
            r       = bus.req_ready;
            was_vld = bus.req_valid;
            v       = bus.rsp_valid;
            d       = bus.rsp_rdata;
            tick();
            if (r && was_vld) acc++;
            if (v) begin
                chk("bp_order", d, 32'hC0DE0000 + 32'(got));
                got++;
            end
        end
        bus.req_valid = 1'b0;
        chk("bp_resp_count", 32'(got), 32'd4);
        chk("bp_accept_count", 32'(acc), 32'd4);
        tick();
        tick();
        chk("bp_no_dup", 32'(bus.rsp_valid), 32'd0);

        // Range check at DEPTH = 1000
        wr(10'd999, 4'b0000, 32'h99999999);
        wr(10'd1000, 4'b0000, 32'h12345678);
        rd_chk("oor_1000", 10'd1000, 32'h00000000, 1'b1);
        rd_chk("oor_1023", 10'd1023, 32'h00000000, 1'b1);
        rd_chk("inr_999", 10'd999, 32'h99999999, 1'b0);

        // Streaming write/read pairs to one address
        drops  = 0;
        got    = 0;
        extra  = 0;
        last_w = '0;
        for (int c = 0; c < 140; c++) begin
            if (c < 128) begin
                bus.req_valid = 1'b1;
                bus.req_addr  = 10'd7;
                bus.req_web   = 4'b0000;
                if (c % 2 == 0) begin
                    bus.req_we    = 1'b1;
                    last_w        = (32'(c) * 32'h01000193) ^ 32'h5A5A5A5A;
                    bus.req_wdata = last_w;
                end else begin
                    bus.req_we = 1'b0;
                    expq.push_back(last_w);
                end
                if (!bus.req_ready) drops++;
            end else begin
                bus.req_valid = 1'b0;
                bus.req_we    = 1'b0;
            end
            v = bus.rsp_valid;
            d = bus.rsp_rdata;
            tick();
            if (v) begin
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    chk("stream_data", d, e);
                    got++;
                end else begin
                    extra++;
                end
            end
        end
        chk("stream_count", 32'(got), 32'd64);
        chk("stream_drops", 32'(drops), 32'd0);
        chk("stream_extra", 32'(extra), 32'd0);

        // Reset with two responses pending
        wr(10'd9, 4'b0000, 32'h600DF00D);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 10'd5;
        tick();
        bus.req_addr  = 10'd9;
        tick();
        bus.req_valid = 1'b0;
        repeat (LAT - 1) tick();
        chk("pend_valid", 32'(bus.rsp_valid), 32'd1);
        chk("pend_head", bus.rsp_rdata, 32'hDE22BE44);
        chk("pend_ready", 32'(bus.req_ready), (BUF == 2) ? 32'd0 : 32'd1);
        RSTn = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("midrst_rsp_rdata", bus.rsp_rdata, 32'd0);
        tick();
        tick();
        RSTn = 1'b1;
        bus.rsp_ready = 1'b1;
        tick();
        chk("postrst_empty", 32'(bus.rsp_valid), 32'd0);
        rd_chk("postrst_a9", 10'd9, 32'h600DF00D, 1'b0);
        rd_chk("postrst_a5", 10'd5, 32'hDE22BE44, 1'b0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
